// File: rtl/pipe_ctrl_n.sv
// Pipeline control: merges stall requests and memwait into stall/bubble vectors, arbitrates redirects.
// Latency: stall/flush/redirect outputs are combinational; a redirect during a stall is held until release.
// Backpressure: a stall on stage k holds every stage upstream; memwait is bounded by a timeout mask.
module pipe_ctrl_n #(
  parameter int NSTAGES     = 5,
  parameter int ADDR_W      = 32,
  parameter int MEM_STAGE   = 3,
  parameter int FLUSH_DEPTH = 2,
  parameter int MAX_WAIT    = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NSTAGES-1:0] stallreq_i,
  input  logic               memwait_i,
  input  logic               branch_flag_i,
  input  logic [ADDR_W-1:0]  branch_addr_i,
  input  logic               trap_i,
  input  logic [ADDR_W-1:0]  trap_addr_i,
  output logic               branch_flag_o,
  output logic [ADDR_W-1:0]  branch_addr_o,
  output logic [NSTAGES-1:0] stall_o,
  output logic [NSTAGES-1:0] flush_o,
  output logic               timeout_o,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   pend_addr;
  logic [ADDR_W-1:0]   pend_addr_nxt;
  logic [7:0]          wait_cnt;
  logic                mw_mask;

  logic                mw_act;
  logic                wait_last;
  logic [NSTAGES-1:0]  req;
  logic [NSTAGES-1:0]  stall;
  logic [NSTAGES-1:0]  bubble;
  logic [NSTAGES-1:0]  redir_mask;
  logic                stall_any;
  logic                redir_evt;
  logic [ADDR_W-1:0]   redir_tgt;
  logic                issue;
  logic [ADDR_W-1:0]   issue_addr;

  assign mw_act    = memwait_i & ~mw_mask;
  assign wait_last = (wait_cnt == 8'(MAX_WAIT - 1));
  assign req       = stallreq_i | ({{(NSTAGES-1){1'b0}}, mw_act} << MEM_STAGE);
  assign stall_any = stall[0];
  assign redir_evt = trap_i | branch_flag_i;
  assign redir_tgt = trap_i ? trap_addr_i : branch_addr_i;

  // Stall propagation: a stalled stage holds itself and every stage upstream of it.
  always_comb begin
    stall = '0;
    stall[NSTAGES-1] = req[NSTAGES-1];
    for (int k = NSTAGES - 2; k >= 0; k--) begin
      stall[k] = stall[k+1] | req[k];
    end
  end

  // Bubble into the first running stage below a stalled one; redirect flush mask for stages 1..FLUSH_DEPTH.
  always_comb begin
    bubble     = '0;
    redir_mask = '0;
    for (int k = 1; k < NSTAGES; k++) begin
      bubble[k] = stall[k-1] & ~stall[k];
      if (k <= FLUSH_DEPTH) redir_mask[k] = 1'b1;
    end
  end

  // Redirect FSM: issue immediately when the pipe moves, otherwise park the target in HOLD.
  always_comb begin
    state_nxt     = state;
    pend_addr_nxt = pend_addr;
    issue         = 1'b0;
    issue_addr    = '0;
    case (state)
      RUN: begin
        if (redir_evt) begin
          if (!stall_any) begin
            issue      = 1'b1;
            issue_addr = redir_tgt;
          end else begin
            state_nxt     = HOLD;
            pend_addr_nxt = redir_tgt;
          end
        end
      end
      HOLD: begin
        if (stall_any) begin
          // Branches seen while parked are wrong-path; only a trap replaces the target.
          if (trap_i) pend_addr_nxt = trap_addr_i;
        end else begin
          issue      = 1'b1;
          issue_addr = trap_i ? trap_addr_i : pend_addr;
          state_nxt  = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // FSM state and parked redirect target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      pend_addr <= '0;
    end else begin
      state     <= state_nxt;
      pend_addr <= pend_addr_nxt;
    end
  end

  // Memwait timeout: count unmasked wait cycles, mask memwait after MAX_WAIT until it drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      mw_mask  <= 1'b0;
    end else if (!memwait_i) begin
      wait_cnt <= '0;
      mw_mask  <= 1'b0;
    end else if (!mw_mask) begin
      if (wait_last) begin
        wait_cnt <= '0;
        mw_mask  <= 1'b1;
      end else begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  // Outputs are forced quiet while reset is held, whatever the request inputs do.
  always_comb begin
    branch_flag_o = rst & issue;
    branch_addr_o = (rst & issue) ? issue_addr : '0;
    stall_o       = rst ? stall : '0;
    flush_o       = rst ? (bubble | (issue ? redir_mask : '0)) : '0;
    timeout_o     = rst & mw_act & wait_last;
    state_o       = state;
  end

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Bench for pipe_ctrl_n: directed scenarios then random traffic against a behavioural model.
// Inputs change 1ns after the rising edge; outputs are compared 1ns later.
module tb_pipe_ctrl_n;
  localparam int N  = 5;
  localparam int MS = 3;
  localparam int FD = 2;
  localparam int MW = 15;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] stallreq_i = '0;
  logic         memwait_i = 1'b0;
  logic         branch_flag_i = 1'b0;
  logic [31:0]  branch_addr_i = '0;
  logic         trap_i = 1'b0;
  logic [31:0]  trap_addr_i = '0;
  logic         branch_flag_o;
  logic [31:0]  branch_addr_o;
  logic [N-1:0] stall_o;
  logic [N-1:0] flush_o;
  logic         timeout_o;
  logic [1:0]   state_o;

  int n_checks = 0;
  int n_errors = 0;

  // model state: redirect parked?, its target, length of the current memwait run
  bit           m_hold;
  logic [31:0]  m_pend;
  int           m_mwlen;

  pipe_ctrl_n #(.NSTAGES(N), .ADDR_W(32), .MEM_STAGE(MS), .FLUSH_DEPTH(FD), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .stallreq_i(stallreq_i), .memwait_i(memwait_i),
    .branch_flag_i(branch_flag_i), .branch_addr_i(branch_addr_i),
    .trap_i(trap_i), .trap_addr_i(trap_addr_i),
    .branch_flag_o(branch_flag_o), .branch_addr_o(branch_addr_o),
    .stall_o(stall_o), .flush_o(flush_o),
    .timeout_o(timeout_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int top_bit(input logic [N-1:0] r);
    int t = -1;
    for (int i = 0; i < N; i++) if (r[i]) t = i;
    return t;
  endfunction

  task automatic model_reset();
    m_hold  = 0;
    m_pend  = '0;
    m_mwlen = 0;
  endtask

  // One cycle: apply inputs, compare outputs with the model, advance the clock and the model.
  task automatic step(input string tag, input logic [N-1:0] sr, input logic mw,
                      input logic br, input logic [31:0] ba,
                      input logic tr, input logic [31:0] ta);
    logic [N-1:0] req, e_stall, e_flush;
    logic         e_issue, e_to, mw_live, busy;
    logic [31:0]  e_addr;
    int           t;
    stallreq_i = sr; memwait_i = mw; branch_flag_i = br; branch_addr_i = ba;
    trap_i = tr; trap_addr_i = ta;
    #1;
    // memwait stalls only for the first MW cycles of a run
    mw_live = mw && (m_mwlen < MW);
    e_to    = mw && (m_mwlen == MW - 1);
    req     = sr | (mw_live ? N'(1 << MS) : N'(0));
    t       = top_bit(req);
    busy    = (t >= 0);
    e_stall = busy ? N'((1 << (t + 1)) - 1) : N'(0);
    e_flush = (busy && t < N - 1) ? N'(1 << (t + 1)) : N'(0);
    e_issue = 0;
    e_addr  = '0;
    if (!m_hold) begin
      if ((br || tr) && !busy) begin
        e_issue = 1; e_addr = tr ? ta : ba;
      end
    end else if (!busy) begin
      e_issue = 1; e_addr = tr ? ta : m_pend;
    end
    if (e_issue) e_flush = e_flush | N'((1 << (FD + 1)) - 2);
    chk({tag, " stall"}, 64'(stall_o), 64'(e_stall));
    chk({tag, " flush"}, 64'(flush_o), 64'(e_flush));
    chk({tag, " bflag"}, 64'(branch_flag_o), 64'(e_issue));
    chk({tag, " baddr"}, 64'(branch_addr_o), 64'(e_addr));
    chk({tag, " tmo"},   64'(timeout_o), 64'(e_to));
    chk({tag, " state"}, 64'(state_o), 64'(m_hold));
    @(posedge clk);
    if (!m_hold) begin
      if ((br || tr) && busy) begin
        m_hold = 1; m_pend = tr ? ta : ba;
      end
    end else if (busy) begin
      if (tr) m_pend = ta;
    end else begin
      m_hold = 0;
    end
    m_mwlen = mw ? ((m_mwlen < 1000) ? m_mwlen + 1 : m_mwlen) : 0;
    #1;
  endtask

  task automatic idle(input string tag);
    step(tag, '0, 0, 0, '0, 0, '0);
  endtask

  initial begin
    logic [N-1:0] sr;
    logic         mw;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle("t1 idle");

    // 1: reset in the middle of HOLD with requests still present
    step("t1 park", 5'b00010, 0, 1, 32'h444, 0, '0);
    step("t1 hold", 5'b00010, 0, 0, '0, 0, '0);
    chk("t1 in_hold", 64'(state_o), 64'd1);
    rst = 1'b0; memwait_i = 1'b1;
    #1;
    chk("t1 rst stall", 64'(stall_o), 64'd0);
    chk("t1 rst flush", 64'(flush_o), 64'd0);
    chk("t1 rst bflag", 64'(branch_flag_o), 64'd0);
    chk("t1 rst baddr", 64'(branch_addr_o), 64'd0);
    chk("t1 rst tmo",   64'(timeout_o), 64'd0);
    chk("t1 rst state", 64'(state_o), 64'd0);
    @(posedge clk); #1;
    stallreq_i = '0; memwait_i = 1'b0; rst = 1'b1;
    model_reset();
    #1;
    chk("t1 rel stall", 64'(stall_o), 64'd0);
    chk("t1 rel flush", 64'(flush_o), 64'd0);
    @(posedge clk); #1;
    idle("t1 no pend");

    // 2: stall on stage 2
    step("t2 st", 5'b00100, 0, 0, '0, 0, '0);
    stallreq_i = 5'b00100; #1;
    chk("t2 stall const", 64'(stall_o), 64'h07);
    chk("t2 flush const", 64'(flush_o), 64'h08);
    @(posedge clk); #1;
    idle("t2 rel");

    // 3: plain branch in RUN
    step("t3 br", '0, 0, 1, 32'h100, 0, '0);
    idle("t3 after");

    // 4a: branch parked while stage 1 stalls
    step("t4a c1", 5'b00010, 0, 1, 32'h200, 0, '0);
    step("t4a c2", 5'b00010, 0, 0, '0, 0, '0);
    step("t4a c3", 5'b00010, 0, 1, 32'h666, 0, '0);
    step("t4a c4", '0, 0, 0, '0, 0, '0);
    // 4b: trap replaces the parked branch target
    step("t4b c1", 5'b00010, 0, 1, 32'h200, 0, '0);
    step("t4b c2", 5'b00010, 0, 0, '0, 1, 32'h8);
    step("t4b c3", 5'b00010, 0, 0, '0, 0, '0);
    step("t4b c4", '0, 0, 0, '0, 0, '0);
    // 4c: trap wins in the release cycle
    step("t4c c1", 5'b10000, 0, 1, 32'h210, 0, '0);
    step("t4c c2", '0, 0, 1, 32'h220, 1, 32'h30);
    idle("t4c c3");

    // 5: trap and branch together
    step("t5 both", '0, 0, 1, 32'h300, 1, 32'h8);

    // 6: long memwait, then a fresh run
    for (int i = 0; i < 20; i++) begin
      memwait_i = 1'b1; stallreq_i = '0; branch_flag_i = 0; trap_i = 0;
      #1;
      chk("t6 stall const", 64'(stall_o), (i < MW) ? 64'h0f : 64'h0);
      chk("t6 tmo const", 64'(timeout_o), 64'(i == MW - 1));
      #1;
      step("t6 mw", '0, 1, 0, '0, 0, '0);
    end
    idle("t6 drop");
    for (int i = 0; i < 3; i++) step("t6 again", '0, 1, 0, '0, 0, '0);
    idle("t6 end");

    // random traffic
    mw = 0;
    for (int i = 0; i < 3000; i++) begin
      sr = '0;
      for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) sr[b] = 1'b1;
      if ($urandom_range(0, 9) == 0) mw = ~mw;
      step("rnd", sr, mw, ($urandom_range(0, 4) == 0), $urandom,
           ($urandom_range(0, 9) == 0), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
